// File: rtl/param_tx_pkg.sv
// Shared definitions for the parameter TX sequencer:
// CSR offsets, CTRL/STATUS bit positions, FSM states.
package param_tx_pkg;

  localparam int RAM_DEPTH_DEF = 1025;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_START  = 2'd1;
  localparam logic [1:0] CSR_COUNT  = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ABORTED  = 2;
  localparam int ST_ERR      = 3;
  localparam int ST_SENT_LSB = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/param_tx_skid_fifo.sv
// 2-entry FIFO holding {sop, eop, data} between RAM read and stream.
// Ports: push/push_data in, pop/pop_data out, count, flush.
module param_tx_skid_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/param_tx_sequencer.sv
// Streams a block of TX RAM words to the serializer under CSR control.
// Ports: Avalon-MM CSR slave, RAM port-2 read master, valid/ready stream, irq.
module param_tx_sequencer
  import param_tx_pkg::*;
#(
  parameter int RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(RAM_DEPTH - 1);

  state_e state_q, state_d;

  logic              irq_en_q;
  logic [ADDR_W-1:0] start_q, count_q;
  logic              done_q, aborted_q, err_q;
  logic [ADDR_W-1:0] sent_q, addr_q, rem_q, blk_q;
  logic              infl_q, infl_sop_q, infl_eop_q;

  logic        wr_ctrl, wr_start, wr_count, wr_stat;
  logic        go, abort, run, args_ok;
  logic        start_ok, err_set, abort_run;
  logic        pop, last_pop, issue, h_sop, h_eop;
  logic [1:0]  fifo_cnt;
  logic [2:0]  in_use;
  logic [31:0] rd_mux;

  assign wr_ctrl  = csr_write && (csr_address == CSR_CTRL);
  assign wr_start = csr_write && (csr_address == CSR_START);
  assign wr_count = csr_write && (csr_address == CSR_COUNT);
  assign wr_stat  = csr_write && (csr_address == CSR_STATUS);

  assign go    = wr_ctrl && csr_writedata[CTRL_GO];
  assign abort = wr_ctrl && csr_writedata[CTRL_ABORT];
  assign run   = (state_q == RUN);

  assign args_ok = (count_q != '0) && (count_q <= DEPTH)
                && (start_q < DEPTH);

  assign start_ok  = go && !abort && !run && args_ok;
  assign err_set   = go && !abort && !run && !args_ok;
  assign abort_run = abort && run;

  assign tx_valid = (fifo_cnt != 2'd0);
  assign pop      = tx_valid && tx_ready;
  assign last_pop = pop && h_eop;
  assign tx_sop   = tx_valid && h_sop;
  assign tx_eop   = tx_valid && h_eop;

  // A word leaving this cycle frees its slot, so a new read may
  // be issued against it; this keeps 1 word/clk with ready high.
  assign in_use = 3'(fifo_cnt) + 3'(infl_q) - 3'(pop);
  assign issue  = run && (rem_q != '0) && (in_use < 3'd2);

  assign ram_address    = addr_q;
  assign ram_chipselect = issue;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign irq            = done_q && irq_en_q;

  param_tx_skid_fifo #(
    .W(DATA_W + 2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (abort_run),
    .push      (infl_q && !abort_run),
    .push_data ({infl_sop_q, infl_eop_q, ram_readdata}),
    .pop       (pop),
    .pop_data  ({h_sop, h_eop, tx_data}),
    .count     (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (abort_run || last_pop) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    rd_mux = '0;
    unique case (csr_address)
      CSR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
      CSR_START:  rd_mux[ADDR_W-1:0] = start_q;
      CSR_COUNT:  rd_mux[ADDR_W-1:0] = count_q;
      CSR_STATUS: begin
        rd_mux[ST_BUSY]    = run;
        rd_mux[ST_DONE]    = done_q;
        rd_mux[ST_ABORTED] = aborted_q;
        rd_mux[ST_ERR]     = err_q;
        rd_mux[ST_SENT_LSB +: ADDR_W] = sent_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata <= '0;
      irq_en_q     <= 1'b0;
      start_q      <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      csr_readdata <= csr_read ? rd_mux : '0;
      if (wr_ctrl)  irq_en_q <= csr_writedata[CTRL_IRQ_EN];
      if (wr_start) start_q  <= csr_writedata[ADDR_W-1:0];
      if (wr_count) count_q  <= csr_writedata[ADDR_W-1:0];
      // W1C clears lose to a same-cycle set.
      done_q <= (done_q && !(wr_stat && csr_writedata[ST_DONE]))
             || (last_pop && !abort_run);
      aborted_q <= (aborted_q
                    && !(wr_stat && csr_writedata[ST_ABORTED]))
                || abort_run;
      err_q <= (err_q && !(wr_stat && csr_writedata[ST_ERR]))
            || err_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      blk_q      <= '0;
      sent_q     <= '0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q <= start_q;
        rem_q  <= count_q;
        blk_q  <= count_q;
      end else if (issue) begin
        addr_q <= (addr_q == LAST) ? '0 : addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      if (start_ok)  sent_q <= '0;
      else if (pop)  sent_q <= sent_q + 1'b1;
      infl_q     <= issue && !abort_run;
      infl_sop_q <= (rem_q == blk_q);
      infl_eop_q <= (rem_q == ADDR_W'(1));
    end
  end

endmodule
